// File: rtl/frame_parser_state_tracer.sv
// Passive tracer for the frame parser: logs state transitions with timestamps into an FWFT FIFO, counts transitions and frames, and raises sticky watchdog errors.
// Latency: an entry is visible on rd_data one cycle after its transition is sampled.
// Backpressure: none upstream; a transition arriving while the FIFO is full and not popped is dropped and sets overflow.
module frame_parser_state_tracer #(
    parameter int                 STATE_W     = 4,
    parameter int                 DEPTH       = 16,
    parameter int                 TS_W        = 16,
    parameter logic [STATE_W-1:0] IDLE_STATE  = '0,
    parameter int                 STALL_LIMIT = 1024,
    parameter int                 HOLD_LIMIT  = 256
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [STATE_W-1:0]           state,
    input  logic                         frame_valid_hold,
    input  logic                         clear,
    input  logic                         rd_en,
    output logic                         rd_valid,
    output logic [2*STATE_W+TS_W-1:0]    rd_data,
    output logic [$clog2(DEPTH):0]       fifo_count,
    output logic                         overflow,
    output logic                         stall_err,
    output logic                         hold_err,
    output logic [15:0]                  transition_cnt,
    output logic [15:0]                  frame_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = 2*STATE_W + TS_W;
    localparam int DW = $clog2(STALL_LIMIT + 1);
    localparam int HW = $clog2(HOLD_LIMIT + 2);

    logic [EW-1:0]      mem [DEPTH];
    logic [STATE_W-1:0] state_q, state_d;
    logic               hold_q, hold_d;
    logic [TS_W-1:0]    ts_q, ts_d;
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]      count_q, count_d;
    logic               overflow_q, overflow_d;
    logic               stall_err_q, stall_err_d;
    logic               hold_err_q, hold_err_d;
    logic [15:0]        trans_cnt_q, trans_cnt_d;
    logic [15:0]        frame_cnt_q, frame_cnt_d;
    logic [DW-1:0]      dwell_q, dwell_d;
    logic [HW-1:0]      hold_cnt_q, hold_cnt_d;
    logic               transition, full, pop, push;

    always_comb begin
        transition  = (state != state_q);
        full        = (count_q == CW'(DEPTH));
        pop         = rd_en && (count_q != '0) && !clear;
        // A full FIFO can still accept a write when the head leaves in the same cycle.
        push        = transition && !clear && (!full || pop);

        state_d     = state;
        hold_d      = frame_valid_hold;
        ts_d        = ts_q + TS_W'(1);
        wr_ptr_d    = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d    = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q | (transition && full && !pop);
        trans_cnt_d = trans_cnt_q;
        frame_cnt_d = frame_cnt_q;
        dwell_d     = dwell_q;
        hold_cnt_d  = '0;

        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        if (transition && trans_cnt_q != 16'hFFFF)
            trans_cnt_d = trans_cnt_q + 16'd1;
        if (frame_valid_hold && !hold_q && frame_cnt_q != 16'hFFFF)
            frame_cnt_d = frame_cnt_q + 16'd1;

        if (transition || state == IDLE_STATE)
            dwell_d = '0;
        else if (dwell_q != DW'(STALL_LIMIT))
            dwell_d = dwell_q + DW'(1);
        stall_err_d = stall_err_q | (dwell_d == DW'(STALL_LIMIT));

        if (frame_valid_hold)
            hold_cnt_d = (hold_cnt_q == HW'(HOLD_LIMIT + 1)) ? hold_cnt_q : hold_cnt_q + HW'(1);
        hold_err_d  = hold_err_q | (hold_cnt_d > HW'(HOLD_LIMIT));

        // state_d / hold_d keep tracking so the cycle after clear sees no stale edge.
        if (clear) begin
            ts_d        = '0;
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            overflow_d  = 1'b0;
            stall_err_d = 1'b0;
            hold_err_d  = 1'b0;
            trans_cnt_d = '0;
            frame_cnt_d = '0;
            dwell_d     = '0;
            hold_cnt_d  = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE_STATE;
            hold_q      <= 1'b0;
            ts_q        <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            stall_err_q <= 1'b0;
            hold_err_q  <= 1'b0;
            trans_cnt_q <= '0;
            frame_cnt_q <= '0;
            dwell_q     <= '0;
            hold_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            ts_q        <= ts_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            stall_err_q <= stall_err_d;
            hold_err_q  <= hold_err_d;
            trans_cnt_q <= trans_cnt_d;
            frame_cnt_q <= frame_cnt_d;
            dwell_q     <= dwell_d;
            hold_cnt_q  <= hold_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !rst)
            mem[wr_ptr_q] <= {state_q, state, ts_q};
    end

    // Storage is not reset, so the head is masked to keep outputs defined when empty.
    assign rd_valid       = (count_q != '0);
    assign rd_data        = rd_valid ? mem[rd_ptr_q] : '0;
    assign fifo_count     = count_q;
    assign overflow       = overflow_q;
    assign stall_err      = stall_err_q;
    assign hold_err       = hold_err_q;
    assign transition_cnt = trans_cnt_q;
    assign frame_cnt      = frame_cnt_q;
endmodule

// File: tb/tb_frame_parser_state_tracer.sv
// Directed bench for frame_parser_state_tracer with STALL_LIMIT=8, HOLD_LIMIT=8.
module tb_frame_parser_state_tracer;
    logic        clk;
    logic        rst;
    logic [3:0]  state;
    logic        frame_valid_hold;
    logic        clear;
    logic        rd_en;
    logic        rd_valid;
    logic [23:0] rd_data;
    logic [4:0]  fifo_count;
    logic        overflow;
    logic        stall_err;
    logic        hold_err;
    logic [15:0] transition_cnt;
    logic [15:0] frame_cnt;

    int vecs = 0;
    int errs = 0;

    frame_parser_state_tracer #(
        .STATE_W(4), .DEPTH(16), .TS_W(16), .IDLE_STATE(4'h0),
        .STALL_LIMIT(8), .HOLD_LIMIT(8)
    ) dut (
        .clk(clk), .rst(rst), .state(state), .frame_valid_hold(frame_valid_hold),
        .clear(clear), .rd_en(rd_en), .rd_valid(rd_valid), .rd_data(rd_data),
        .fifo_count(fifo_count), .overflow(overflow), .stall_err(stall_err),
        .hold_err(hold_err), .transition_cnt(transition_cnt), .frame_cnt(frame_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    function automatic logic [23:0] ent(input logic [3:0] p, input logic [3:0] n, input logic [15:0] t);
        return {p, n, t};
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"},  rd_valid,       0);
        check({tag, "_data"},   rd_data,        0);
        check({tag, "_count"},  fifo_count,     0);
        check({tag, "_ovf"},    overflow,       0);
        check({tag, "_stall"},  stall_err,      0);
        check({tag, "_hold"},   hold_err,       0);
        check({tag, "_tcnt"},   transition_cnt, 0);
        check({tag, "_fcnt"},   frame_cnt,      0);
    endtask

    initial begin
        rst = 1'b1; state = 4'h0; frame_valid_hold = 1'b0; clear = 1'b0; rd_en = 1'b0;

        // T1: reset
        step(3);
        check_all_zero("t1_in_rst");
        rst = 1'b0;
        check_all_zero("t1_after_rst");

        // T2: edges P1..P5 sample ts 0..4, so 0->3 lands at ts=5 and 3->7 at ts=9
        step(5);
        state = 4'h3;
        step(1);
        check("t2_first_vis_valid", rd_valid, 1);
        check("t2_first_vis_data", rd_data, ent(4'h0, 4'h3, 16'd5));
        step(3);
        state = 4'h7;
        step(1);
        check("t2_count", fifo_count, 2);
        check("t2_tcnt", transition_cnt, 2);
        check("t2_head0", rd_data, ent(4'h0, 4'h3, 16'd5));
        rd_en = 1'b1;
        step(1);
        check("t2_head1", rd_data, ent(4'h3, 4'h7, 16'd9));
        check("t2_count1", fifo_count, 1);
        step(1);
        check("t2_empty", rd_valid, 0);
        step(1);
        check("t2_pop_empty_ignored", fifo_count, 0);
        rd_en = 1'b0;

        // T3: overflow; clear restarts ts so entry k carries ts=k
        clear = 1'b1;
        step(1);
        clear = 1'b0;
        check("t3_clr_tcnt", transition_cnt, 0);
        for (int i = 0; i < 17; i++) begin
            state = (i % 2 == 0) ? 4'h1 : 4'h2;
            step(1);
        end
        check("t3_count", fifo_count, 16);
        check("t3_ovf", overflow, 1);
        check("t3_tcnt", transition_cnt, 17);
        check("t3_head", rd_data, ent(4'h7, 4'h1, 16'd0));
        state = 4'h2;
        rd_en = 1'b1;
        step(1);
        rd_en = 1'b0;
        check("t3_fullpop_count", fifo_count, 16);
        check("t3_fullpop_head", rd_data, ent(4'h1, 4'h2, 16'd1));
        check("t3_fullpop_tcnt", transition_cnt, 18);
        check("t3_ovf_sticky", overflow, 1);

        // T4: stall watchdog
        clear = 1'b1;
        step(1);
        clear = 1'b0;
        check("t4_clr_ovf", overflow, 0);
        state = 4'h4;
        step(1);
        step(7);
        check("t4_stall_7", stall_err, 0);
        step(1);
        check("t4_stall_8", stall_err, 1);
        check("t4_count", fifo_count, 1);

        // T6a: clear coincident with a transition (4->0)
        state = 4'h0;
        clear = 1'b1;
        step(1);
        clear = 1'b0;
        check("t6_clr_count", fifo_count, 0);
        check("t6_clr_tcnt", transition_cnt, 0);
        check("t6_clr_stall", stall_err, 0);
        check("t6_clr_valid", rd_valid, 0);
        step(1);
        check("t6_clr_no_late_entry", fifo_count, 0);

        // T4b: idle never stalls
        step(100);
        check("t4_idle_stall", stall_err, 0);

        // T5: hold watchdog and frame count
        frame_valid_hold = 1'b1;
        step(8);
        check("t5_hold_8", hold_err, 0);
        step(1);
        check("t5_hold_9", hold_err, 1);
        frame_valid_hold = 1'b0;
        step(1);
        for (int p = 0; p < 2; p++) begin
            frame_valid_hold = 1'b1;
            step(1);
            frame_valid_hold = 1'b0;
            step(1);
        end
        check("t5_frame_cnt", frame_cnt, 3);
        check("t5_hold_sticky", hold_err, 1);

        // T6b: async reset in the middle of a burst
        for (int i = 0; i < 3; i++) begin
            state = 4'h5 + 4'(i);
            step(1);
        end
        check("t6_burst_count", fifo_count, 3);
        rst = 1'b1;
        #1;
        check_all_zero("t6_async_rst");
        @(negedge clk);
        rst = 1'b0;
        state = 4'h0;
        step(1);
        check("t6_post_rst_count", fifo_count, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
